// File: rtl/mac_burst_accum.sv
// Pipelined multiply-accumulate: sums a burst of operand pairs delimited by in_last
// and reports one dot-product per burst, with optional saturation and sticky overflow.
module mac_burst_accum #(
    parameter int DATA_W   = 4,
    parameter int ACC_W    = 10,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1,
    parameter int MAX_LEN  = 16,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out,
    output logic              overflow,
    output logic              len_err,
    output logic [CW-1:0]     beat_cnt
);

    localparam int EW = ACC_W + 2;
    localparam bit SX = (SIGNED != 0);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;
    state_t state;

    logic [CW-1:0] cnt, cnt_nxt;
    logic          beat, forced, last_eff;

    logic [DATA_W-1:0]          a_p1, b_p1;
    logic                       vld_p1, first_p1, last_p1, lerr_p1;
    logic [CW-1:0]              cnt_p1;
    logic signed [2*DATA_W-1:0] prod_p2;
    logic                       vld_p2, first_p2, last_p2, lerr_p2;
    logic [CW-1:0]              cnt_p2;
    logic signed [ACC_W-1:0]    acc_p3;
    logic                       vld_p3, ovf_p3, lerr_p3;
    logic [CW-1:0]              cnt_p3;

    logic signed [2*DATA_W-1:0] a_x, b_x, prod_c;
    logic signed [EW-1:0]       prod_ext, acc_ext, sum;

    // Two guard bits above ACC_W expose both unsigned carry-out and signed overflow.
    function automatic logic ovf_chk(input logic signed [EW-1:0] s);
        if (SX) return !((s[EW-1:ACC_W-1] == '0) || (s[EW-1:ACC_W-1] == '1));
        return s[EW-1:ACC_W] != '0;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [EW-1:0] s);
        if (SATURATE == 0 || !ovf_chk(s)) return s[ACC_W-1:0];
        if (SX) return s[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return '1;
    endfunction

    assign beat     = in_valid && in_ready && !clr;
    assign cnt_nxt  = cnt + 1'b1;
    assign forced   = (cnt_nxt == CW'(MAX_LEN));
    assign last_eff = in_last || forced;

    always_comb begin
        a_x      = {{DATA_W{SX && a_p1[DATA_W-1]}}, a_p1};
        b_x      = {{DATA_W{SX && b_p1[DATA_W-1]}}, b_p1};
        prod_c   = a_x * b_x;
        prod_ext = {{(EW-2*DATA_W){SX && prod_p2[2*DATA_W-1]}}, prod_p2};
        acc_ext  = first_p2 ? '0 : {{2{SX && acc_p3[ACC_W-1]}}, acc_p3};
        sum      = acc_ext + prod_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            cnt       <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            acc_p3    <= '0;
            ovf_p3    <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            overflow  <= 1'b0;
            len_err   <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                state    <= IDLE;
                in_ready <= 1'b1;
                cnt      <= '0;
                vld_p1   <= 1'b0;
                vld_p2   <= 1'b0;
                vld_p3   <= 1'b0;
                ovf_p3   <= 1'b0;
            end else begin
                vld_p1 <= beat;
                vld_p2 <= vld_p1;
                vld_p3 <= vld_p2 && last_p2;
                case (state)
                    IDLE, ACC: if (beat) begin
                        state    <= last_eff ? DRAIN : ACC;
                        in_ready <= !last_eff;
                        cnt      <= last_eff ? '0 : cnt_nxt;
                    end
                    default: if (vld_p3) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                endcase
                // E2: accumulate (first beat replaces the running sum)
                if (vld_p2) begin
                    acc_p3 <= sat(sum);
                    ovf_p3 <= (ovf_p3 && !first_p2) || ovf_chk(sum);
                end
                // E3: report the finished burst
                if (vld_p3) begin
                    out_valid <= 1'b1;
                    out       <= acc_p3;
                    overflow  <= ovf_p3;
                    len_err   <= lerr_p3;
                    beat_cnt  <= cnt_p3;
                end
            end
        end
    end

    // E0: capture beat; E1: full-width product
    always_ff @(posedge clk) begin
        if (beat) begin
            a_p1     <= in1;
            b_p1     <= in2;
            first_p1 <= (state == IDLE);
            last_p1  <= last_eff;
            lerr_p1  <= forced && !in_last;
            cnt_p1   <= cnt_nxt;
        end
        if (vld_p1) begin
            prod_p2  <= prod_c;
            first_p2 <= first_p1;
            last_p2  <= last_p1;
            lerr_p2  <= lerr_p1;
            cnt_p2   <= cnt_p1;
        end
        if (vld_p2 && last_p2) begin
            lerr_p3 <= lerr_p2;
            cnt_p3  <= cnt_p2;
        end
    end

endmodule

// File: tb/tb_mac_burst_accum.sv
// Directed bench for mac_burst_accum: three configurations (unsigned/saturate,
// unsigned/wrap, signed/saturate) share one stimulus stream and a per-instance scoreboard.
module tb_mac_burst_accum;

    logic       clk, rst_n, clr, in_valid, in_last;
    logic [3:0] in1, in2;
    logic       rdy  [3];
    logic       ovld [3];
    logic [9:0] o    [3];
    logic       ovf  [3];
    logic       lerr [3];
    logic [4:0] bc   [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] out;
        logic       ovf;
        logic       lerr;
        logic [4:0] cnt;
        longint     t;
    } exp_t;
    exp_t q0[$], q1[$], q2[$];

    int m_acc [3];
    bit m_ovf [3];
    bit m_first = 1'b1;
    int m_cnt = 0;
    int sg [3] = '{0, 0, 1};
    int st [3] = '{1, 0, 1};

    mac_burst_accum #(.DATA_W(4), .ACC_W(10), .SIGNED(0), .SATURATE(1), .MAX_LEN(16)) u_us (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .in1(in1), .in2(in2), .in_ready(rdy[0]), .out_valid(ovld[0]), .out(o[0]),
        .overflow(ovf[0]), .len_err(lerr[0]), .beat_cnt(bc[0]));
    mac_burst_accum #(.DATA_W(4), .ACC_W(10), .SIGNED(0), .SATURATE(0), .MAX_LEN(16)) u_uw (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .in1(in1), .in2(in2), .in_ready(rdy[1]), .out_valid(ovld[1]), .out(o[1]),
        .overflow(ovf[1]), .len_err(lerr[1]), .beat_cnt(bc[1]));
    mac_burst_accum #(.DATA_W(4), .ACC_W(10), .SIGNED(1), .SATURATE(1), .MAX_LEN(16)) u_ss (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_last(in_last),
        .in1(in1), .in2(in2), .in_ready(rdy[2]), .out_valid(ovld[2]), .out(o[2]),
        .overflow(ovf[2]), .len_err(lerr[2]), .beat_cnt(bc[2]));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Reference accumulation with unbounded integers, clamped or wrapped afterwards.
    function automatic void model(input logic [3:0] a, input logic [3:0] b, input logic last,
                                  input longint t);
        int p, s, lo, hi;
        bit ov, forced;
        exp_t e;
        forced = (m_cnt + 1 == 16);
        for (int k = 0; k < 3; k++) begin
            p  = sg[k] ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
            s  = (m_first ? 0 : m_acc[k]) + p;
            lo = sg[k] ? -512 : 0;
            hi = sg[k] ? 511 : 1023;
            ov = (s < lo) || (s > hi);
            if (ov) begin
                if (st[k] != 0) s = (s > hi) ? hi : lo;
                else begin
                    s = s & 1023;
                    if (sg[k] != 0 && s > 511) s = s - 1024;
                end
            end
            m_acc[k] = s;
            m_ovf[k] = (m_first ? 1'b0 : m_ovf[k]) | ov;
            if (last || forced) begin
                e.out  = s[9:0];
                e.ovf  = m_ovf[k];
                e.lerr = forced && !last;
                e.cnt  = 5'(m_cnt + 1);
                e.t    = t + 35;
                push(k, e);
            end
        end
        if (last || forced) begin
            m_first = 1'b1;
            m_cnt   = 0;
        end else begin
            m_first = 1'b0;
            m_cnt   = m_cnt + 1;
        end
    endfunction

    task automatic mon(input int k);
        exp_t e;
        bit have = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            chk($sformatf("dut%0d_unexpected_valid", k), ovld[k], 0);
            return;
        end
        chk($sformatf("dut%0d_out", k), o[k], e.out);
        chk($sformatf("dut%0d_overflow", k), ovf[k], e.ovf);
        chk($sformatf("dut%0d_len_err", k), lerr[k], e.lerr);
        chk($sformatf("dut%0d_beat_cnt", k), bc[k], e.cnt);
        chk($sformatf("dut%0d_latency_time", k), $time, e.t);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) if (ovld[k]) mon(k);
        end
    end

    task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic last);
        int g = 0;
        while (rdy[0] !== 1'b1 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) begin
            chk("ready_timeout", rdy[0], 1);
            return;
        end
        in_valid = 1'b1; in1 = a; in2 = b; in_last = last;
        @(posedge clk);
        model(a, b, last, $time);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        int g;
        clk = 0; rst_n = 0; clr = 0; in_valid = 0; in_last = 0; in1 = 0; in2 = 0;
        #12;
        chk("rst_in_ready", rdy[0], 1);
        chk("rst_out_valid", ovld[0], 0);
        chk("rst_out", o[0], 0);
        chk("rst_overflow", ovf[0], 0);
        chk("rst_len_err", lerr[0], 0);
        chk("rst_beat_cnt", bc[0], 0);
        #8 rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) beat(4'd15, 4'd15, i == 3);
        for (int i = 0; i < 5; i++) beat(4'd15, 4'd15, i == 4);
        beat(4'd8, 4'd7, 0); beat(4'd3, 4'd14, 0); beat(4'd8, 4'd8, 1);
        beat(4'd8, 4'd8, 1);

        beat(4'd2, 4'd3, 1);
        chk("b2b_ready_drain0", rdy[0], 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("b2b_ready_drain", rdy[0], 0);
        end
        @(posedge clk); #1;
        chk("b2b_ready_back", rdy[0], 1);
        chk("b2b_valid_with_ready", ovld[0], 1);
        beat(4'd1, 4'd1, 1);

        beat(4'd1, 4'd2, 0);
        repeat (2) @(posedge clk);
        #1 beat(4'd3, 4'd4, 1);

        for (int i = 0; i < 19; i++) beat(4'd1, 4'd1, i == 18);

        beat(4'd2, 4'd2, 0); beat(4'd2, 4'd2, 0);
        clr = 1; in_valid = 1; in1 = 4'd5; in2 = 4'd5; in_last = 1;
        @(posedge clk); #1;
        clr = 0; in_valid = 0; in_last = 0;
        m_first = 1'b1; m_cnt = 0;
        chk("clr_in_ready", rdy[0], 1);
        repeat (5) @(posedge clk);
        #1 beat(4'd4, 4'd4, 1);

        beat(4'd3, 4'd3, 0); beat(4'd3, 4'd3, 0);
        rst_n = 0;
        #2;
        chk("midrst_out", o[0], 0);
        chk("midrst_in_ready", rdy[0], 1);
        chk("midrst_out_valid", ovld[0], 0);
        #1 rst_n = 1;
        m_first = 1'b1; m_cnt = 0;
        repeat (5) @(posedge clk);
        #1 beat(4'd4, 4'd4, 1);

        g = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        repeat (5) @(posedge clk);
        chk("pending_dut0", q0.size(), 0);
        chk("pending_dut1", q1.size(), 0);
        chk("pending_dut2", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
